// File: rtl/interp_rate_scheduler.sv
// interp_rate_scheduler: rate-domain clock enables, one-word input buffer and underflow flagging for an interpolation chain
// Ports:
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   clk_enable_i   master tick at output (modulator) rate
//   run_i          1 = start/keep running, 0 = stop at the end of the current frame
//   in_valid_i     upstream sample valid
//   in_data_i      upstream sample
//   in_ready_o     buffer empty, can accept a sample
//   ce_vec_o       per-domain enables, [0] = output rate, [k] = 1/2**k rate
//   sample_out_o   sample for the input stage, valid with ce_vec_o[INTERP_LOG2]
//   underflow_o    1-cycle pulse: input tick found the buffer empty
//   uflow_sticky_o sticky underflow, cleared by clr_status_i
//   clr_status_i   clears the sticky flag (and the counter when present)
//   busy_o         scheduler not idle
//   uflow_count_o  saturating underflow count, present only with SCHED_UFLOW_CNT_EN defined
module interp_rate_scheduler #(
    parameter int DATA_W      = 20,
    parameter int INTERP_LOG2 = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   clk_enable_i,
    input  logic                   run_i,
    input  logic                   in_valid_i,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic                   in_ready_o,
    output logic [INTERP_LOG2:0]   ce_vec_o,
    output logic [DATA_W-1:0]      sample_out_o,
    output logic                   underflow_o,
    output logic                   uflow_sticky_o,
    input  logic                   clr_status_i,
    output logic                   busy_o
`ifdef SCHED_UFLOW_CNT_EN
    ,output logic [15:0]           uflow_count_o
`endif
);
    typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;
    state_e                 state_q, state_d;
    logic [INTERP_LOG2-1:0] phase_q, phase_d;
    logic [INTERP_LOG2:0]   ce_q, ce_d;
    logic [DATA_W-1:0]      buf_q, buf_d, out_q, out_d;
    logic                   full_q, full_d, uf_q, uf_d, sticky_q, sticky_d;
    logic                   tick, in_tick, frame_end;
    always_comb begin
        tick      = (state_q == RUN) && clk_enable_i;
        in_tick   = tick && (phase_q == '0);
        frame_end = tick && (phase_q == '1);
        // domain k fires when the low k phase bits are all zero
        for (int k = 0; k <= INTERP_LOG2; k++)
            ce_d[k] = tick && ((phase_q & ~({INTERP_LOG2{1'b1}} << k)) == '0);
        phase_d  = (state_q != RUN) ? '0 : phase_q + INTERP_LOG2'(tick);
        state_d  = (state_q == IDLE  && run_i)              ? PRIME :
                   (state_q == PRIME && full_q)             ? RUN   :
                   (state_q == RUN   && frame_end && !run_i) ? IDLE : state_q;
        uf_d     = in_tick && !full_q;
        out_d    = (in_tick && full_q) ? buf_q : out_q;
        buf_d    = (in_valid_i && !full_q) ? in_data_i : buf_q;
        // capture needs an empty buffer and consume a full one, so they never collide
        full_d   = (in_tick && full_q) ? 1'b0 : (in_valid_i && !full_q) ? 1'b1 : full_q;
        sticky_d = uf_d || (sticky_q && !clr_status_i);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            phase_q  <= '0;
            ce_q     <= '0;
            buf_q    <= '0;
            out_q    <= '0;
            full_q   <= 1'b0;
            uf_q     <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            ce_q     <= ce_d;
            buf_q    <= buf_d;
            out_q    <= out_d;
            full_q   <= full_d;
            uf_q     <= uf_d;
            sticky_q <= sticky_d;
        end
    end
`ifdef SCHED_UFLOW_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    // a new underflow wins over clear, so the count restarts at 1
    assign cnt_d = clr_status_i ? 16'(uf_d) : (uf_d && cnt_q != '1) ? cnt_q + 16'd1 : cnt_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign uflow_count_o = cnt_q;
`endif
    assign in_ready_o     = !full_q;
    assign ce_vec_o       = ce_q;
    assign sample_out_o   = out_q;
    assign underflow_o    = uf_q;
    assign uflow_sticky_o = sticky_q;
    assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_interp_rate_scheduler.sv
// tb_interp_rate_scheduler: scoreboard bench for interp_rate_scheduler
module tb_interp_rate_scheduler;
    localparam int DW = 20;
    localparam int L  = 4;
    logic          clk = 1'b0, rst_n = 1'b0, clk_enable = 1'b0, run = 1'b0;
    logic          in_valid = 1'b0, clr_status = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready, underflow, uflow_sticky, busy;
    logic [L:0]    ce_vec;
    logic [DW-1:0] sample_out;
`ifdef SCHED_UFLOW_CNT_EN
    logic [15:0]   uflow_count;
`endif
    int            checks = 0, errors = 0;
    int            period = 1, cnt = 0, src_left = 0, q_pre = 0, cyc = 0;
    bit            pushed_last = 0, prev_pushed = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] hist[$];
    logic [DW-1:0] last_out = '0;

    interp_rate_scheduler #(.DATA_W(DW), .INTERP_LOG2(L)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clk_enable_i(clk_enable), .run_i(run),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .ce_vec_o(ce_vec), .sample_out_o(sample_out), .underflow_o(underflow),
        .uflow_sticky_o(uflow_sticky), .clr_status_i(clr_status), .busy_o(busy)
`ifdef SCHED_UFLOW_CNT_EN
        ,.uflow_count_o(uflow_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance to the next falling edge (outputs of the last rising edge are now
    // observable), then drive the source and clock enable for the next rising edge.
    task automatic cycle();
        logic [DW-1:0] v;
        @(negedge clk);
        cyc++;
        prev_pushed = pushed_last;
        q_pre       = q.size();
        cnt++;
        clk_enable  = (cnt % period == 0);
        pushed_last = 0;
        if (src_left > 0 && in_ready) begin
            v        = DW'($urandom) | DW'(1);
            in_valid = 1'b1;
            in_data  = v;
            q.push_back(v);
            hist.push_back(v);
            src_left--;
            pushed_last = 1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; src_left = 0; in_valid = 1'b0; clr_status = 1'b0;
        q.delete(); hist.delete(); last_out = '0; pushed_last = 0; cnt = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        checks++; if (ce_vec !== '0)       $display("FAIL reset_ce_vec: got %b expected 0", ce_vec);
        checks++; if (sample_out !== '0)   $display("FAIL reset_sample_out: got %h expected 0", sample_out);
        checks++; if (underflow !== 1'b0)  $display("FAIL reset_underflow: got %b expected 0", underflow);
        checks++; if (uflow_sticky !== 1'b0) $display("FAIL reset_sticky: got %b expected 0", uflow_sticky);
        checks++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b expected 0", busy);
        errors += (in_ready !== 1'b1) + (ce_vec !== '0) + (sample_out !== '0) + (underflow !== 1'b0)
                + (uflow_sticky !== 1'b0) + (busy !== 1'b0);
    endtask

    // Continuous run with clk_enable every p cycles: checks enable spacing,
    // alignment at phase 0 and the sample order through the scoreboard.
    task automatic test_rates(input int p, input int n);
        int  l0 = -1, l2 = -1, l4 = -1;
        bit  exp_uf;
        do_reset();
        period = p; src_left = 100000; run = 1'b1;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (ce_vec[0]) begin
                if (l0 < 0) begin
                    checks++;
                    if (ce_vec[L] !== 1'b1) begin errors++; $display("FAIL first_tick_aligned: got ce_vec=%b expected all ones", ce_vec); end
                end else begin
                    checks++;
                    if (cyc - l0 != p) begin errors++; $display("FAIL ce0_interval: got %0d expected %0d", cyc - l0, p); end
                end
                l0 = cyc;
            end
            if (ce_vec[2]) begin
                if (l2 >= 0) begin
                    checks++;
                    if (cyc - l2 != 4 * p) begin errors++; $display("FAIL ce2_interval: got %0d expected %0d", cyc - l2, 4 * p); end
                end
                l2 = cyc;
            end
            if (ce_vec[L]) begin
                if (l4 >= 0) begin
                    checks++;
                    if (cyc - l4 != 16 * p) begin errors++; $display("FAIL ce4_interval: got %0d expected %0d", cyc - l4, 16 * p); end
                end
                l4 = cyc;
                checks++;
                if (ce_vec !== '1) begin errors++; $display("FAIL ce_aligned: got %b expected all ones", ce_vec); end
                exp_uf = (q_pre - int'(prev_pushed)) == 0;
                if (!exp_uf) last_out = q.pop_front();
                checks++;
                if (underflow !== exp_uf) begin errors++; $display("FAIL rate_underflow: got %b expected %b", underflow, exp_uf); end
                checks++;
                if (sample_out !== last_out) begin errors++; $display("FAIL rate_sample: got %h expected %h", sample_out, last_out); end
            end else begin
                checks++;
                if (underflow !== 1'b0) begin errors++; $display("FAIL rate_spurious_underflow: got %b expected 0", underflow); end
            end
        end
        checks++;
        if (l4 < 0) begin errors++; $display("FAIL rate_no_input_tick: got none expected ce_vec[%0d]", L); end
    endtask

    task automatic test_underflow();
        int ticks = 0;
        bit exp_uf;
        do_reset();
        period = 1; src_left = 2; run = 1'b1;
        for (int i = 0; i < 100 && ticks < 3; i++) begin
            cycle();
            if (ce_vec[L]) begin
                ticks++;
                exp_uf = (q_pre - int'(prev_pushed)) == 0;
                if (!exp_uf) last_out = q.pop_front();
                checks++;
                if (underflow !== exp_uf) begin errors++; $display("FAIL uf_pulse_tick%0d: got %b expected %b", ticks, underflow, exp_uf); end
                checks++;
                if (sample_out !== last_out) begin errors++; $display("FAIL uf_sample_tick%0d: got %h expected %h", ticks, sample_out, last_out); end
                if (ticks == 2) begin
                    checks++;
                    if (uflow_sticky !== 1'b0) begin errors++; $display("FAIL uf_sticky_early: got %b expected 0", uflow_sticky); end
                end
            end
        end
        checks++;
        if (ticks < 3) begin errors++; $display("FAIL uf_timeout: got %0d ticks expected 3", ticks); end
        checks++;
        if (hist.size() != 2 || sample_out !== hist[1]) begin errors++; $display("FAIL uf_holds_second: got %h expected second sample", sample_out); end
        checks++;
        if (underflow !== 1'b1 || uflow_sticky !== 1'b1) begin errors++; $display("FAIL uf_flags: got uf=%b sticky=%b expected 1 1", underflow, uflow_sticky); end
`ifdef SCHED_UFLOW_CNT_EN
        checks++;
        if (uflow_count !== 16'd1) begin errors++; $display("FAIL uf_count1: got %0d expected 1", uflow_count); end
`endif
        clr_status = 1'b1;
        cycle();
        clr_status = 1'b0;
        checks++;
        if (uflow_sticky !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got sticky=%b uf=%b expected 0 0", uflow_sticky, underflow); end
`ifdef SCHED_UFLOW_CNT_EN
        checks++;
        if (uflow_count !== 16'd0) begin errors++; $display("FAIL uf_count_clear: got %0d expected 0", uflow_count); end
`endif
        repeat (14) cycle();
        clr_status = 1'b1;
        cycle();
        clr_status = 1'b0;
        checks++;
        if (ce_vec[L] !== 1'b1 || underflow !== 1'b1 || uflow_sticky !== 1'b1) begin
            errors++; $display("FAIL uf_clr_collide: got ce=%b uf=%b sticky=%b expected 1 1 1", ce_vec[L], underflow, uflow_sticky);
        end
`ifdef SCHED_UFLOW_CNT_EN
        checks++;
        if (uflow_count !== 16'd1) begin errors++; $display("FAIL uf_count_collide: got %0d expected 1", uflow_count); end
`endif
        repeat (16) cycle();
        checks++;
        if (underflow !== 1'b1 || sample_out !== hist[1]) begin errors++; $display("FAIL uf_repeat: got uf=%b sample=%h expected 1 %h", underflow, sample_out, hist[1]); end
`ifdef SCHED_UFLOW_CNT_EN
        checks++;
        if (uflow_count !== 16'd2) begin errors++; $display("FAIL uf_count2: got %0d expected 2", uflow_count); end
`endif
    endtask

    // run drops when phase is 5: ticks for phases 5..15 still appear, then idle.
    task automatic test_stop();
        int n0 = 0, n2 = 0, n4 = 0;
        bit seen = 0;
        do_reset();
        period = 1; src_left = 100000; run = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle();
            seen = ce_vec[L];
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL stop_no_tick: got none expected input tick"); end
        repeat (4) cycle();
        run = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n0 += int'(ce_vec[0]);
            n2 += int'(ce_vec[2]);
            n4 += int'(ce_vec[L]);
        end
        checks++;
        if (n0 != 11) begin errors++; $display("FAIL stop_ce0_count: got %0d expected 11", n0); end
        checks++;
        if (n2 != 2) begin errors++; $display("FAIL stop_ce2_count: got %0d expected 2", n2); end
        checks++;
        if (n4 != 0) begin errors++; $display("FAIL stop_ce4_count: got %0d expected 0", n4); end
        checks++;
        if (busy !== 1'b0 || ce_vec !== '0) begin errors++; $display("FAIL stop_idle: got busy=%b ce=%b expected 0 0", busy, ce_vec); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        period = 1; src_left = 100000; run = 1'b1;
        repeat (25) cycle();
        checks++;
        if (busy !== 1'b1 || sample_out === '0) begin errors++; $display("FAIL midrun_active: got busy=%b sample=%h expected running", busy, sample_out); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ce_vec !== '0 || sample_out !== '0 || underflow !== 1'b0 || uflow_sticky !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got ce=%b sample=%h uf=%b sticky=%b ready=%b busy=%b expected 0 0 0 0 1 0",
                     ce_vec, sample_out, underflow, uflow_sticky, in_ready, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ce_vec !== '0) begin errors++; $display("FAIL midrun_held: got busy=%b ce=%b expected 0 0", busy, ce_vec); end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_rates(1, 120);
        test_rates(3, 300);
        test_underflow();
        test_stop();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
